neuron_sequencer: RTL and testbench
===================================

# neuron_sequencer

Control stage directly upstream of the CORDIC `MAC` in the neuron datapath. It holds one neuron's activation/weight operand pairs in a small register file and, on `go`, streams them into the MAC one term at a time. For each term it generates the MAC's `start`/`counter`/`stop` protocol and skips zero products. It then reads back the MAC accumulator and returns that neuron's sum through a valid/ready result port. The MAC accumulator has no clear, so the sum is reported relative to a snapshot taken at job start.

## Interface
- `N_INPUTS`, 8: operand pairs per neuron (1..16).
- `DW`, 8: operand width (fixed to the MAC operand width).
- `ITER`, 8: MAC multiply iterations per term; `mac_counter` spans 0..ITER-1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ld_valid` in 1: operand write request.
- `ld_ready` out 1: high only in IDLE.
- `ld_addr` in 4: term index; writes with `ld_addr` ≥ N_INPUTS are dropped.
- `ld_a`, `ld_w` in 8 each: activation and weight.
- `go` in 1: start a job; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `mac_an`, `mac_wn` out 8 each: MAC operands, held for the whole term.
- `mac_counter` out 3: MAC iteration index.
- `mac_start`, `mac_stop` out 1 each: MAC control pulses.
- `mac_acc` in 16: MAC accumulator output.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_sum` out 16: neuron sum, mod 2^16.

## Operation
- Reset (`rst_n`=0 at an edge): state goes to IDLE.
  - All outputs except `ld_ready` go to 0: `mac_*`, `res_*`, `busy`.
  - `ld_ready` goes to 1 after reset (IDLE).
  - Register file cleared to zero; term index cleared.
  - Reset mid-job aborts with no further `mac_stop`.
- States:
  - IDLE
  - SNAP: capture `base` ← `mac_acc`.
  - FETCH: read pair[idx]. If a==0 or w==0, skip: idx++, and go to SETTLE if it was the last term, else stay in FETCH. Otherwise drive `mac_an`/`mac_wn` and go to START.
  - START: `mac_start`=1, `mac_counter`=0.
  - ITER: 8 cycles, `mac_counter`=0..7.
  - STOP: `mac_stop`=1, `mac_counter`=7; idx++; go to FETCH or SETTLE.
  - SETTLE: wait one cycle for the MAC accumulator to update.
  - DONE: `res_sum` = (`mac_acc` − `base`) mod 2^16, captured on entry; `res_valid`=1.
- Transitions: DONE→IDLE on `res_valid`&&`res_ready`.
- `mac_start` and `mac_stop` are single-cycle pulses and are never high in the same cycle.
- `ld_valid` and `go` in the same IDLE cycle: the write lands first, so the job uses the new value.
- `go` while `busy`: ignored, not queued. `ld_valid` while not IDLE: ignored.
- Arithmetic: subtraction is unsigned 16-bit wrap. Accumulator overflow within a job is not detected; the caller guarantees range.

## Timing
- `go` sampled at edge T. SNAP is in cycle T+1.
- Each term costs 1 FETCH cycle; a non-zero term adds 10 cycles (START + 8 ITER + STOP).
- `res_valid` first high in cycle T + 3 + N_INPUTS + 10·NZ, where NZ is the number of non-zero terms.
- `res_valid` and `res_sum` stay stable until the handshake completes. The next `go` is accepted the cycle after.
- `mac_an`/`mac_wn` hold from FETCH through STOP; they are unchanged across a skip.

## Structure
- Package `neuron_pkg`:
  - state enum (IDLE, SNAP, FETCH, START, ITER, STOP, SETTLE, DONE)
  - `DW`=8, `ACC_W`=16, `ITER`=8, `IDX_W`=4
- Sub-module `operand_regfile`: N_INPUTS × (a,w), synchronous write, combinational read, synchronous clear. Everything else lives in `neuron_sequencer`.

## Test plan
- N_INPUTS=4, A={1,2,3,4}, W={5,6,7,8}, go → `res_sum`=70; `res_valid` at T+47; exactly 4 `mac_start` pulses.
- N_INPUTS=4, A={0,3,0,0}, W={9,2,5,0} → `res_sum`=6; 1 start/stop pair; `res_valid` at T+17.
- Two consecutive jobs, no reset: job1 = sum 70, job2 A={10,0,0,0}, W={10,…} → second `res_sum`=100, not 170.
- N_INPUTS=8, all A=W=255 → `res_sum`=61448 (520200 mod 65536).
- Hold `res_ready`=0 for 5 cycles in DONE → `res_sum` stable, `busy`=1, `ld_ready`=0, a `go` pulse ignored.
- Assert `rst_n`=0 during ITER → next cycle all `mac_*`=0 and `res_valid`=0. A following `go` with no loads gives `res_sum`=0 at T+3+N_INPUTS.

Source files
------------

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_pkg
//  Description : Shared widths and the sequencer state encoding for the
//                neuron operand sequencer. Imported by the interface, the
//                register file and the sequencer top.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    localparam int DW    = 8;              // MAC operand width
    localparam int ACC_W = 16;             // MAC accumulator width
    localparam int ITER  = 8;              // MAC iterations per term
    localparam int IDX_W = 4;              // term index width (up to 16 terms)
    localparam int CNT_W = $clog2(ITER);   // mac_counter width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNAP   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_START  = 3'd3,
        ST_ITER   = 3'd4,
        ST_STOP   = 3'd5,
        ST_SETTLE = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/neuron_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_sequencer_if
//  Description : Bus bundle between the neuron sequencer and its environment:
//                operand load port, job control, MAC drive/readback and the
//                valid/ready result port.
//                slave  - sequencer side
//                master - environment side (loader, MAC, result consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface neuron_sequencer_if;
    import neuron_pkg::*;

    // operand load
    logic             ld_valid;
    logic             ld_ready;
    logic [IDX_W-1:0] ld_addr;
    logic [DW-1:0]    ld_a;
    logic [DW-1:0]    ld_w;
    // job control
    logic             go;
    logic             busy;
    // MAC side
    logic [DW-1:0]    mac_an;
    logic [DW-1:0]    mac_wn;
    logic [CNT_W-1:0] mac_counter;
    logic             mac_start;
    logic             mac_stop;
    logic [ACC_W-1:0] mac_acc;
    // result
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_sum;

    modport slave (
        input  ld_valid, ld_addr, ld_a, ld_w, go, mac_acc, res_ready,
        output ld_ready, busy, mac_an, mac_wn, mac_counter, mac_start,
               mac_stop, res_valid, res_sum
    );

    modport master (
        output ld_valid, ld_addr, ld_a, ld_w, go, mac_acc, res_ready,
        input  ld_ready, busy, mac_an, mac_wn, mac_counter, mac_start,
               mac_stop, res_valid, res_sum
    );

endinterface
`default_nettype wire

// File: rtl/neuron_sequencer_operand_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : operand_regfile
//  Description : Activation/weight pair storage for one neuron.
//                Synchronous write, combinational read, synchronous clear.
//  Ports       : clk, rst_n         - clock, synchronous active-low clear
//                i_wr_en/i_wr_addr  - write strobe and term index
//                i_wr_a/i_wr_w      - activation / weight write data
//                i_rd_addr          - read term index
//                o_rd_a/o_rd_w      - activation / weight read data
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_regfile
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_wr_en,
    input  wire logic [IDX_W-1:0] i_wr_addr,
    input  wire logic [DW-1:0]    i_wr_a,
    input  wire logic [DW-1:0]    i_wr_w,
    input  wire logic [IDX_W-1:0] i_rd_addr,
    output logic      [DW-1:0]    o_rd_a,
    output logic      [DW-1:0]    o_rd_w
);

    // The array spans the full index range so any index is a legal read.
    // Entries at N_INPUTS and above are never written and stay zero.
    localparam int c_DEPTH = 1 << IDX_W;

    logic [DW-1:0] r_a [c_DEPTH];
    logic [DW-1:0] r_w [c_DEPTH];
    logic          w_in_range;

    assign w_in_range = (32'(i_wr_addr) < 32'(N_INPUTS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_a[i] <= '0;
                r_w[i] <= '0;
            end
        end else if (i_wr_en && w_in_range) begin
            r_a[i_wr_addr] <= i_wr_a;
            r_w[i_wr_addr] <= i_wr_w;
        end
    end

    assign o_rd_a = r_a[i_rd_addr];
    assign o_rd_w = r_w[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/neuron_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_sequencer
//  Description : Streams one neuron's operand pairs into the MAC a term at a
//                time, skipping zero products, then returns the accumulator
//                delta since job start on a valid/ready result port.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                bus    - neuron_sequencer_if.slave (load, go/busy, MAC
//                         drive and readback, result handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    neuron_sequencer_if.slave bus
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(ITER - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [ACC_W-1:0] r_base;
    logic             r_ld_ready;
    logic             r_busy;
    logic [DW-1:0]    r_mac_an;
    logic [DW-1:0]    r_mac_wn;
    logic [CNT_W-1:0] r_mac_counter;
    logic             r_mac_start;
    logic             r_mac_stop;
    logic             r_res_valid;
    logic [ACC_W-1:0] r_res_sum;

    logic [DW-1:0]    w_rd_a;
    logic [DW-1:0]    w_rd_w;
    logic             w_wr_en;
    logic             w_last;
    logic             w_skip;

    // Loads only land while idle; a load in the same cycle as go is written
    // long before the first FETCH reads it.
    assign w_wr_en = bus.ld_valid && (r_state == ST_IDLE);
    assign w_last  = (r_idx == c_LAST_IDX);
    assign w_skip  = (w_rd_a == '0) || (w_rd_w == '0);

    operand_regfile #(
        .N_INPUTS (N_INPUTS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.ld_addr),
        .i_wr_a    (bus.ld_a),
        .i_wr_w    (bus.ld_w),
        .i_rd_addr (r_idx),
        .o_rd_a    (w_rd_a),
        .o_rd_w    (w_rd_w)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_base        <= '0;
            r_ld_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_mac_an      <= '0;
            r_mac_wn      <= '0;
            r_mac_counter <= '0;
            r_mac_start   <= 1'b0;
            r_mac_stop    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_sum     <= '0;
        end else begin
            // start/stop are one-cycle pulses, raised only on entry to
            // START / STOP respectively
            r_mac_start <= 1'b0;
            r_mac_stop  <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (bus.go) begin
                        r_state    <= ST_SNAP;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_ld_ready <= 1'b0;
                    end
                end
                ST_SNAP: begin
                    // the MAC accumulator is never cleared; remember where
                    // this job started from
                    r_base  <= bus.mac_acc;
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_skip) begin
                        // operands left untouched so the MAC inputs do not
                        // toggle across a skipped term
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= w_last ? ST_SETTLE : ST_FETCH;
                    end else begin
                        r_mac_an      <= w_rd_a;
                        r_mac_wn      <= w_rd_w;
                        r_mac_start   <= 1'b1;
                        r_mac_counter <= '0;
                        r_state       <= ST_START;
                    end
                end
                ST_START: begin
                    r_mac_counter <= '0;
                    r_state       <= ST_ITER;
                end
                ST_ITER: begin
                    if (r_mac_counter == c_CNT_LAST) begin
                        // counter stays at its last value through STOP
                        r_mac_stop <= 1'b1;
                        r_state    <= ST_STOP;
                    end else begin
                        r_mac_counter <= r_mac_counter + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    r_idx   <= r_idx + IDX_W'(1);
                    r_state <= w_last ? ST_SETTLE : ST_FETCH;
                end
                ST_SETTLE: begin
                    // accumulator has absorbed the last term by now
                    r_res_sum   <= bus.mac_acc - r_base;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ld_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready    = r_ld_ready;
    assign bus.busy        = r_busy;
    assign bus.mac_an      = r_mac_an;
    assign bus.mac_wn      = r_mac_wn;
    assign bus.mac_counter = r_mac_counter;
    assign bus.mac_start   = r_mac_start;
    assign bus.mac_stop    = r_mac_stop;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_sum     = r_res_sum;

endmodule
`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_sequencer
//  Description : Self-checking bench for neuron_sequencer. Two instances
//                (4 and 8 terms) share the load bus; a behavioural MAC adds
//                an*wn on every stop pulse. Expected sums, start counts and
//                latencies come from a plain array model of the operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_sequencer;
    import neuron_pkg::*;

    localparam int TIMEOUT = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_sequencer_if ifc4 ();
    neuron_sequencer_if ifc8 ();

    neuron_sequencer #(.N_INPUTS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4));
    neuron_sequencer #(.N_INPUTS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));

    // shared stimulus
    logic             ld_valid  = 1'b0;
    logic [IDX_W-1:0] ld_addr   = '0;
    logic [DW-1:0]    ld_a      = '0;
    logic [DW-1:0]    ld_w      = '0;
    logic             go        = 1'b0;
    logic             res_ready = 1'b0;
    int               sel       = 0;

    // behavioural MAC accumulators, deliberately not starting at zero
    logic [ACC_W-1:0] acc [2];
    initial begin
        acc[0] = 16'h1234;
        acc[1] = 16'hBEEF;
    end

    assign ifc4.ld_valid  = ld_valid;  assign ifc8.ld_valid  = ld_valid;
    assign ifc4.ld_addr   = ld_addr;   assign ifc8.ld_addr   = ld_addr;
    assign ifc4.ld_a      = ld_a;      assign ifc8.ld_a      = ld_a;
    assign ifc4.ld_w      = ld_w;      assign ifc8.ld_w      = ld_w;
    assign ifc4.res_ready = res_ready; assign ifc8.res_ready = res_ready;
    assign ifc4.go        = go && (sel == 0);
    assign ifc8.go        = go && (sel == 1);
    assign ifc4.mac_acc   = acc[0];
    assign ifc8.mac_acc   = acc[1];

    // observation of the selected instance
    logic             w_valid, w_busy, w_ldr, w_start, w_stop;
    logic [ACC_W-1:0] w_sum;
    logic [DW-1:0]    w_an, w_wn;
    logic [CNT_W-1:0] w_cnt;
    assign w_valid = (sel == 1) ? ifc8.res_valid   : ifc4.res_valid;
    assign w_busy  = (sel == 1) ? ifc8.busy        : ifc4.busy;
    assign w_ldr   = (sel == 1) ? ifc8.ld_ready    : ifc4.ld_ready;
    assign w_sum   = (sel == 1) ? ifc8.res_sum     : ifc4.res_sum;
    assign w_start = (sel == 1) ? ifc8.mac_start   : ifc4.mac_start;
    assign w_stop  = (sel == 1) ? ifc8.mac_stop    : ifc4.mac_stop;
    assign w_an    = (sel == 1) ? ifc8.mac_an      : ifc4.mac_an;
    assign w_wn    = (sel == 1) ? ifc8.mac_wn      : ifc4.mac_wn;
    assign w_cnt   = (sel == 1) ? ifc8.mac_counter : ifc4.mac_counter;

    // MAC model and protocol monitor
    int starts [2] = '{0, 0};
    int stops  [2] = '{0, 0};
    int perr       = 0;
    always @(posedge clk) begin
        if (ifc4.mac_stop === 1'b1) acc[0] <= acc[0] + 16'(ifc4.mac_an) * 16'(ifc4.mac_wn);
        if (ifc8.mac_stop === 1'b1) acc[1] <= acc[1] + 16'(ifc8.mac_an) * 16'(ifc8.mac_wn);
        if (ifc4.mac_start === 1'b1) starts[0]++;
        if (ifc8.mac_start === 1'b1) starts[1]++;
        if (ifc4.mac_stop === 1'b1)  stops[0]++;
        if (ifc8.mac_stop === 1'b1)  stops[1]++;
        if (ifc4.mac_start === 1'b1 && (ifc4.mac_stop !== 1'b0 || ifc4.mac_counter !== '0)) perr++;
        if (ifc8.mac_start === 1'b1 && (ifc8.mac_stop !== 1'b0 || ifc8.mac_counter !== '0)) perr++;
        if (ifc4.mac_stop === 1'b1 && ifc4.mac_counter !== 3'd7) perr++;
        if (ifc8.mac_stop === 1'b1 && ifc8.mac_counter !== 3'd7) perr++;
    end

    // reference operand store: [instance][term]
    logic [DW-1:0] ra [2][8];
    logic [DW-1:0] rw [2][8];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int s);
        return (s == 1) ? 8 : 4;
    endfunction

    function automatic void note_load(input logic [IDX_W-1:0] addr, input logic [DW-1:0] a, input logic [DW-1:0] w);
        for (int s = 0; s < 2; s++) begin
            if (int'(addr) < n_of(s)) begin
                ra[s][addr[2:0]] = a;
                rw[s][addr[2:0]] = w;
            end
        end
    endfunction

    function automatic void clear_ref();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++) begin
                ra[s][i] = '0;
                rw[s][i] = '0;
            end
    endfunction

    function automatic void expect_job(input int s, output int sum, output int nz);
        int total;
        total = 0;
        nz    = 0;
        for (int i = 0; i < n_of(s); i++) begin
            total += int'(ra[s][i]) * int'(rw[s][i]);
            if (ra[s][i] != 0 && rw[s][i] != 0) nz++;
        end
        sum = total % 65536;
    endfunction

    function automatic logic [DW-1:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return '0;
        return DW'($urandom_range(1, 255));
    endfunction

    task automatic load(input logic [IDX_W-1:0] addr, input logic [DW-1:0] a, input logic [DW-1:0] w);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = addr; ld_a = a; ld_w = w;
        note_load(addr, a, w);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Runs one job on instance s. Optionally writes one pair in the go cycle.
    // Holds res_ready low for 'hold' cycles in DONE while poking go and a load.
    task automatic run_job(input int s, input int hold, input bit ldg,
                           input logic [IDX_W-1:0] gaddr, input logic [DW-1:0] ga, input logic [DW-1:0] gw,
                           input string tag);
        int esum, enz, elat, lat, st0, sp0;
        logic [ACC_W-1:0] held;
        sel = s;
        @(negedge clk);
        st0 = starts[s];
        sp0 = stops[s];
        go  = 1'b1;
        if (ldg) begin
            ld_valid = 1'b1; ld_addr = gaddr; ld_a = ga; ld_w = gw;
            note_load(gaddr, ga, gw);
        end
        expect_job(s, esum, enz);
        elat = 3 + n_of(s) + 10 * enz;
        @(negedge clk);
        go = 1'b0; ld_valid = 1'b0;
        lat = 1;
        while (w_valid !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, elat);
        check_eq({tag, "_sum"}, w_sum, esum);
        check_eq({tag, "_starts"}, starts[s] - st0, enz);
        check_eq({tag, "_stops"}, stops[s] - sp0, enz);
        held = w_sum;
        for (int i = 0; i < hold; i++) begin
            go       = (i == 1);
            ld_valid = (i == 2);
            ld_addr  = '0; ld_a = 8'hA5; ld_w = 8'h5A;
            @(negedge clk);
            check_eq({tag, "_hold_sum"}, w_sum, held);
            check_eq({tag, "_hold_valid"}, w_valid, 1);
            check_eq({tag, "_hold_busy"}, w_busy, 1);
            check_eq({tag, "_hold_ldready"}, w_ldr, 0);
        end
        go = 1'b0; ld_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq({tag, "_after_valid"}, w_valid, 0);
        check_eq({tag, "_after_busy"}, w_busy, 0);
        check_eq({tag, "_after_ldready"}, w_ldr, 1);
    endtask

    initial begin
        int seen, sp0;
        clear_ref();

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check_eq("rst_ldready", w_ldr, 1);
            check_eq("rst_busy", w_busy, 0);
            check_eq("rst_valid", w_valid, 0);
            check_eq("rst_sum", w_sum, 0);
            check_eq("rst_start", w_start, 0);
            check_eq("rst_stop", w_stop, 0);
            check_eq("rst_cnt", w_cnt, 0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed ----------------
        for (int i = 0; i < 4; i++) load(IDX_W'(i), DW'(i + 1), DW'(i + 5));
        run_job(0, 5, 1'b0, '0, '0, '0, "dense4");                  // 70 @ 47

        load(4'd0, 8'd0, 8'd9);
        load(4'd1, 8'd3, 8'd2);
        load(4'd2, 8'd0, 8'd5);
        run_job(0, 0, 1'b1, 4'd3, 8'd0, 8'd0, "sparse4");           // 6 @ 17

        for (int i = 0; i < 4; i++) load(IDX_W'(i), DW'(i + 1), DW'(i + 5));
        run_job(0, 0, 1'b0, '0, '0, '0, "seqA");                    // 70
        load(4'd0, 8'd10, 8'd10);
        load(4'd1, 8'd0, 8'd7);
        load(4'd2, 8'd0, 8'd3);
        load(4'd3, 8'd0, 8'd1);
        run_job(0, 0, 1'b0, '0, '0, '0, "seqB");                    // 100

        for (int i = 0; i < 8; i++) load(IDX_W'(i), 8'd255, 8'd255);
        load(4'd12, 8'd77, 8'd77);                                  // dropped
        run_job(1, 2, 1'b0, '0, '0, '0, "max8");                    // 61448

        // ---------------- randomized ----------------
        for (int j = 0; j < 10; j++) begin
            int nl;
            nl = $urandom_range(0, 6);
            for (int k = 0; k < nl; k++)
                load(IDX_W'($urandom_range(0, 15)), rnd_op(), rnd_op());
            run_job($urandom_range(0, 1), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 15)),
                    rnd_op(), rnd_op(), "rand");
        end

        // ---------------- reset mid-job ----------------
        for (int i = 0; i < 4; i++) load(IDX_W'(i), 8'd3, 8'd4);
        sel = 0;
        @(negedge clk);
        sp0 = stops[0];
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            if (w_start === 1'b1) seen = 1;
            else @(negedge clk);
        end
        check_eq("rst_mid_start_seen", seen, 1);
        repeat (4) @(negedge clk);
        check_eq("rst_mid_in_iter_busy", w_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_start", w_start, 0);
        check_eq("rst_mid_stop", w_stop, 0);
        check_eq("rst_mid_cnt", w_cnt, 0);
        check_eq("rst_mid_an", w_an, 0);
        check_eq("rst_mid_wn", w_wn, 0);
        check_eq("rst_mid_valid", w_valid, 0);
        check_eq("rst_mid_busy", w_busy, 0);
        check_eq("rst_mid_ldready", w_ldr, 1);
        rst_n = 1'b1;
        clear_ref();
        repeat (15) @(negedge clk);
        check_eq("rst_mid_no_stop", stops[0] - sp0, 0);
        run_job(0, 0, 1'b0, '0, '0, '0, "post_rst");                // 0 @ 7

        check_eq("mac_protocol", perr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
